// File: rtl/line_window_buffer_pkg.sv
// Shared types and helpers for the ping-pong line window buffer.
package line_buffer_pkg;

  typedef enum logic {
    EDGE_ZERO      = 1'b0,
    EDGE_REPLICATE = 1'b1
  } edge_mode_e;

  // Pointer width for a line of n pixels; never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Tap k of a window holds pixel x+k and occupies the k-th pixel-wide slice.
  function automatic int tap_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/line_window_buffer_if.sv
// Pixel-in / window-out stream bundle; the buffer sits on the slave side.
interface line_window_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN        = 3
);
  logic                      i_valid;
  logic [DATA_WIDTH-1:0]     i_data;
  logic                      o_ready;
  logic                      i_ready;
  logic [WIN*DATA_WIDTH-1:0] o_data;
  logic                      o_valid;
  logic                      o_last;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_data, o_valid, o_last
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_data, o_valid, o_last
  );
endinterface

// File: rtl/line_window_buffer_bank.sv
// One line of pixel storage: a single write port and WIN combinational
// read taps starting at i_raddr, with edge handling past the line end.
module line_bank
  import line_buffer_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         LINE_WIDTH = 512,
  parameter int         WIN        = 3,
  parameter edge_mode_e EDGE_MODE  = EDGE_ZERO,
  localparam int        PW         = ptr_w(LINE_WIDTH)
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic [PW-1:0]             i_waddr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [PW-1:0]             i_raddr,
  output logic [WIN*DATA_WIDTH-1:0] o_taps
);

  logic [DATA_WIDTH-1:0] r_mem [LINE_WIDTH];
  logic [DATA_WIDTH-1:0] w_edge;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign w_edge = (EDGE_MODE == EDGE_REPLICATE) ? r_mem[LINE_WIDTH-1] : '0;

  // One extra index bit so x+k past the line end is detectable.
  for (genvar k = 0; k < WIN; k++) begin : g_tap
    logic [PW:0] w_idx;
    assign w_idx = {1'b0, i_raddr} + (PW+1)'(k);
    assign o_taps[tap_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
      (w_idx >= (PW+1)'(LINE_WIDTH)) ? w_edge : r_mem[w_idx[PW-1:0]];
  end

endmodule

// File: rtl/line_window_buffer.sv
// Ping-pong line buffer: lines are written alternately into two banks while
// the other bank is read out as WIN-pixel horizontal windows.
module line_window_buffer
  import line_buffer_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         LINE_WIDTH = 512,
  parameter int         WIN        = 3,
  parameter edge_mode_e EDGE_MODE  = EDGE_ZERO,
  localparam int        PW         = ptr_w(LINE_WIDTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  line_window_buffer_if.slave bus
);

  logic [1:0]                r_full;
  logic [1:0]                w_full_nxt;
  logic                      r_wr_bank;
  logic                      r_rd_bank;
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic [WIN*DATA_WIDTH-1:0] r_win_p1;
  logic                      r_vld_p1;
  logic                      r_last_p1;

  logic                      w_ready;
  logic                      w_accept;
  logic                      w_load;
  logic                      w_wr_last;
  logic                      w_rd_last;
  logic [WIN*DATA_WIDTH-1:0] w_taps0;
  logic [WIN*DATA_WIDTH-1:0] w_taps1;
  logic [WIN*DATA_WIDTH-1:0] w_taps;

  assign w_ready   = !r_full[r_wr_bank];
  assign w_accept  = bus.i_valid && w_ready;
  assign w_load    = r_full[r_rd_bank] && (!r_vld_p1 || bus.i_ready);
  assign w_wr_last = (r_wr_ptr == PW'(LINE_WIDTH-1));
  assign w_rd_last = (r_rd_ptr == PW'(LINE_WIDTH-1));

  line_bank #(
    .DATA_WIDTH(DATA_WIDTH), .LINE_WIDTH(LINE_WIDTH), .WIN(WIN), .EDGE_MODE(EDGE_MODE)
  ) u_bank0 (
    .i_clk(i_clk), .i_we(w_accept && !r_wr_bank), .i_waddr(r_wr_ptr),
    .i_wdata(bus.i_data), .i_raddr(r_rd_ptr), .o_taps(w_taps0)
  );

  line_bank #(
    .DATA_WIDTH(DATA_WIDTH), .LINE_WIDTH(LINE_WIDTH), .WIN(WIN), .EDGE_MODE(EDGE_MODE)
  ) u_bank1 (
    .i_clk(i_clk), .i_we(w_accept && r_wr_bank), .i_waddr(r_wr_ptr),
    .i_wdata(bus.i_data), .i_raddr(r_rd_ptr), .o_taps(w_taps1)
  );

  assign w_taps = r_rd_bank ? w_taps1 : w_taps0;

  // Writer and reader never set and clear the same bank in one cycle.
  always_comb begin
    w_full_nxt = r_full;
    if (w_accept && w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_load && w_rd_last)   w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) begin
        r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + PW'(1);
        if (w_wr_last) r_wr_bank <= ~r_wr_bank;
      end
      if (w_load) begin
        r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + PW'(1);
        if (w_rd_last) r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // ---- stage p1: registered window output ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_win_p1  <= '0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else if (w_load) begin
      r_win_p1  <= w_taps;
      r_vld_p1  <= 1'b1;
      r_last_p1 <= w_rd_last;
    end else if (bus.i_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_data  = r_win_p1;
  assign bus.o_valid = r_vld_p1;
  assign bus.o_last  = r_last_p1;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer: a per-cycle vector table for one line,
// then stream sequences for back-pressure, continuous, random-stall and reset cases.
module tb_line_window_buffer;
  import line_buffer_pkg::*;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int W  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          t_reset;
  logic          t_valid;
  logic          t_ready;
  logic [DW-1:0] t_data;

  line_window_buffer_if #(.DATA_WIDTH(DW), .WIN(W)) bz ();
  line_window_buffer_if #(.DATA_WIDTH(DW), .WIN(W)) br ();

  assign bz.i_valid = t_valid;
  assign bz.i_data  = t_data;
  assign bz.i_ready = t_ready;
  assign br.i_valid = t_valid;
  assign br.i_data  = t_data;
  assign br.i_ready = t_ready;

  line_window_buffer #(
    .DATA_WIDTH(DW), .LINE_WIDTH(LW), .WIN(W), .EDGE_MODE(EDGE_ZERO)
  ) dut_z (.i_clk(clk), .i_reset(t_reset), .bus(bz.slave));

  line_window_buffer #(
    .DATA_WIDTH(DW), .LINE_WIDTH(LW), .WIN(W), .EDGE_MODE(EDGE_REPLICATE)
  ) dut_r (.i_clk(clk), .i_reset(t_reset), .bus(br.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [W*DW-1:0] act, input logic [W*DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          rdy;
    logic          e_ordy;
    logic          e_vld;
    logic          e_last;
    logic [W*DW-1:0] e_z;
    logic [W*DW-1:0] e_r;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [DW-1:0] pix(input int line, input int x);
    return DW'((line + 1) * 16 + x + 1);
  endfunction

  function automatic logic [W*DW-1:0] exp_win(input int line, input int x, input bit rep);
    logic [W*DW-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
      if (x + k < LW)  w[k*DW +: DW] = pix(line, x + k);
      else if (rep)    w[k*DW +: DW] = pix(line, LW - 1);
    end
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    t_reset = 1'b1;
    t_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    t_reset = 1'b0;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low for 30 cycles then high
  task automatic stream(input int line0, input int nlines, input int mode,
                        output int first_low, output int low_cyc,
                        output int ordy6, output int ordy7);
    int acc, got, nlast, total;
    bit held;
    logic [W*DW-1:0] hd;
    logic hl;
    acc = 0; got = 0; nlast = 0; held = 0; hd = '0; hl = 1'b0;
    first_low = -1; low_cyc = 0; ordy6 = -1; ordy7 = -1;
    total = nlines * LW;
    for (int cyc = 0; cyc < 4000 && got < total; cyc++) begin
      @(negedge clk);
      case (mode)
        0:       t_ready = 1'b1;
        1:       t_ready = 1'($urandom_range(0, 1));
        default: t_ready = (cyc >= 30);
      endcase
      if (held) begin
        held = 0;
        check1("hold_valid", bz.o_valid, 1'b1);
        checkw("hold_data", bz.o_data, hd);
        check1("hold_last", bz.o_last, hl);
      end
      if (bz.o_valid && t_ready) begin
        if (got == 6) ordy6 = int'(bz.o_ready);
        if (got == 7) ordy7 = int'(bz.o_ready);
        checkw("win_zero", bz.o_data, exp_win(line0 + got / LW, got % LW, 1'b0));
        checkw("win_rep", br.o_data, exp_win(line0 + got / LW, got % LW, 1'b1));
        check1("win_last", bz.o_last, (got % LW) == LW - 1);
        if (bz.o_last) nlast++;
        got++;
      end else if (bz.o_valid) begin
        held = 1;
        hd   = bz.o_data;
        hl   = bz.o_last;
      end
      if (!bz.o_ready) begin
        if (acc < total) low_cyc++;
        if (first_low < 0) first_low = acc;
      end
      if (acc < total && bz.o_ready) begin
        t_valid = 1'b1;
        t_data  = pix(line0 + acc / LW, acc % LW);
        acc++;
      end else begin
        t_valid = 1'b0;
      end
    end
    checki("window_count", got, total);
    checki("last_count", nlast, nlines);
    @(negedge clk);
    t_valid = 1'b0;
    t_ready = 1'b1;
    @(negedge clk);
    check1("drained", bz.o_valid, 1'b0);
  endtask

  int fl, lc, r6, r7;

  initial begin
    t_reset = 1'b1;
    t_valid = 1'b0;
    t_ready = 1'b0;
    t_data  = '0;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, DW'(i + 1), 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000};
    tbl[8]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h030201, 24'h030201};
    tbl[9]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h040302, 24'h040302};
    tbl[10] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h050403, 24'h050403};
    tbl[11] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h060504, 24'h060504};
    tbl[12] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h070605, 24'h070605};
    tbl[13] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h080706, 24'h080706};
    tbl[14] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000807, 24'h080807};
    tbl[15] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000008, 24'h080808};
    tbl[16] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000008, 24'h080808};

    do_reset();
    check1("rst_o_ready", bz.o_ready, 1'b1);
    check1("rst_o_valid", bz.o_valid, 1'b0);
    check1("rst_o_last", bz.o_last, 1'b0);
    checkw("rst_o_data", bz.o_data, '0);

    // Single line 1..8: row i drives its inputs, then checks after the next edge.
    for (int i = 0; i < 17; i++) begin
      t_valid = tbl[i].v;
      t_data  = tbl[i].d;
      t_ready = tbl[i].rdy;
      @(negedge clk);
      check1("tbl_o_ready", bz.o_ready, tbl[i].e_ordy);
      check1("tbl_o_valid", bz.o_valid, tbl[i].e_vld);
      check1("tbl_o_last", bz.o_last, tbl[i].e_last);
      checkw("tbl_data_zero", bz.o_data, tbl[i].e_z);
      checkw("tbl_data_rep", br.o_data, tbl[i].e_r);
    end

    // Three lines with downstream stalled: both banks fill, then line 1 drains.
    do_reset();
    stream(0, 3, 2, fl, lc, r6, r7);
    checki("ordy_fall_after_pixels", fl, 16);
    checki("ordy_before_line1_last", r6, 0);
    checki("ordy_after_line1_last", r7, 1);

    // Continuous stream, four lines.
    do_reset();
    stream(0, 4, 0, fl, lc, r6, r7);
    checki("ordy_low_cycles", lc, 0);

    // Random downstream stalls.
    stream(4, 3, 1, fl, lc, r6, r7);

    // Reset after a full line plus five pixels of the next one.
    t_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      t_valid = 1'b1;
      t_data  = pix(7 + i / LW, i % LW);
    end
    @(negedge clk);
    t_valid = 1'b0;
    t_reset = 1'b1;
    @(negedge clk);
    t_reset = 1'b0;
    check1("mid_rst_o_valid", bz.o_valid, 1'b0);
    check1("mid_rst_o_ready", bz.o_ready, 1'b1);
    check1("mid_rst_o_last", bz.o_last, 1'b0);
    stream(9, 1, 0, fl, lc, r6, r7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_window_buffer.md
# line_window_buffer

Parametrised ping-pong line buffer for the image-processing pipeline.
It accepts one pixel per cycle on an AXI-stream-style slave port and stores complete lines alternately in two banks.
For every pixel position of a stored line, it emits a horizontal window of `WIN` consecutive pixels on a master port, with configurable edge handling and an end-of-line marker.
Double buffering lets the next line be written while the previous one is read out, so continuous streams run at one pixel and one window per cycle.

## Interface
- `DATA_WIDTH`, default 8: bits per pixel.
- `LINE_WIDTH`, default 512: pixels per line; must be ≥ 2.
- `WIN`, default 3: window taps; 1 ≤ `WIN` ≤ `LINE_WIDTH`.
- `EDGE_MODE`, default `EDGE_ZERO`: out-of-line taps are zero (`EDGE_ZERO`) or replicate the last pixel (`EDGE_REPLICATE`).
- Clock and reset (already decided): `i_clk` is the clock; `i_reset` is synchronous, active-high.
- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous reset, active-high.
- `i_valid`  in  1  slave pixel valid.
- `i_data`  in  `DATA_WIDTH`  slave pixel.
- `o_ready`  out  1  slave ready.
- `i_ready`  in  1  master ready (downstream).
- `o_data`  out  `WIN*DATA_WIDTH`  window; tap k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]` and holds pixel x+k.
- `o_valid`  out  1  master valid.
- `o_last`  out  1  marks the last window of a line (x = `LINE_WIDTH-1`).

## Operation
- State: two banks (0/1), registered `full[1:0]`, `wr_bank`, `wr_ptr`, `rd_bank`, `rd_ptr`. Pointers are `$clog2(LINE_WIDTH)` bits wide.
- Write:
  - `o_ready = !full[wr_bank]`, driven combinationally from registered flags.
  - A pixel is accepted on an edge with `i_valid && o_ready`. It is written to `bank[wr_bank][wr_ptr]` and `wr_ptr` increments.
  - On accepting pixel `LINE_WIDTH-1`: `wr_ptr` wraps to 0, `full[wr_bank]` is set, and `wr_bank` toggles.
- Read:
  - The output register loads when `full[rd_bank] && (!o_valid || i_ready)`.
  - On load: `o_data` gets taps x..x+`WIN`-1 at x = `rd_ptr`; `o_valid` goes to 1; `o_last` becomes `(rd_ptr == LINE_WIDTH-1)`; `rd_ptr` increments.
  - When the loaded window is the last one: `rd_ptr` wraps to 0, `full[rd_bank]` is cleared, and `rd_bank` toggles. The bank is freed at load, not at acceptance.
  - Otherwise, if `i_ready` is high, `o_valid` goes to 0.
  - `o_data` and `o_last` hold their values when no load occurs.
- Edge taps: a tap with x+k ≥ `LINE_WIDTH` is 0 (`EDGE_ZERO`) or pixel `LINE_WIDTH-1` (`EDGE_REPLICATE`). With `WIN` = 1 there are no edge taps.
- Simultaneous events:
  - The writer completes bank B in the same cycle the reader frees bank A: both flag updates apply, and `o_ready` is high in the next cycle with no gap.
  - The writer and reader never target the same bank for set and clear in the same cycle.
- Both banks full: `o_ready` is low until the reader loads the last window of `rd_bank`.
- Reset at any point:
  - all flags, pointers and bank selects go to 0;
  - any partial line is discarded;
  - bank contents are not cleared.

## Timing
- Reset values: `o_ready`=1, `o_valid`=0, `o_last`=0, `o_data`=0.
- Latency: if the last pixel of a line is accepted at edge E, window 0 is loaded at E+1 and is visible after E+1.
- Throughput: one window per cycle while `i_ready` is high and a full bank exists.
- Handshake: while `o_valid && !i_ready`, `o_data` and `o_last` are stable, and `o_valid` never drops without acceptance.
- No combinational path from `i_ready` or `i_valid` to any output.

## Structure
- `line_buffer_pkg`:
  - `edge_mode_e` enum (`EDGE_ZERO`, `EDGE_REPLICATE`);
  - a pointer-width helper function;
  - the tap-index convention.
- Sub-module `line_bank`: a register array of `LINE_WIDTH` × `DATA_WIDTH` with one write port and `WIN` combinational read ports, including edge-tap selection. It is instantiated twice; the top level muxes the banks by `rd_bank`.
- Control (flags, pointers, output register) lives in the top level.

## Test plan
All scenarios use `LINE_WIDTH`=8, `WIN`=3, `DATA_WIDTH`=8.
- Single line 1..8, `EDGE_ZERO`, `i_ready`=1 -> windows `{3,2,1}`, `{4,3,2}` … `{8,7,6}`, `{0,8,7}`, `{0,0,8}`; `o_last` only on the 8th; first `o_valid` is 1 cycle after the 8th pixel is accepted.
- Same line with `EDGE_REPLICATE` -> last two windows are `{8,8,7}` and `{8,8,8}`.
- Three lines back-to-back with `i_ready`=0 -> `o_ready` falls after the 16th accepted pixel; raising `i_ready` gives 8 windows of line 1, then `o_ready` rises in the cycle after the last line-1 window loads.
- Continuous input with `i_ready`=1 for 4 lines -> `o_ready` never low, 32 windows, 4 `o_last` pulses, no duplicates.
- Random `i_ready` toggling -> `o_data` held stable while stalled; the scoreboard sees every window exactly once, in order.
- Reset after 5 pixels of line 2 -> `o_valid`=0 and `o_ready`=1 the next cycle; the following 8 pixels produce a complete, correct line with no stale windows.
